// File: rtl/alu_sequencer.sv
// Hardwired control sequencer that runs one register-register ALU instruction (T0..T5).
// Define SEQ_MEM_WAIT_EN to hold T1 until mem_ready; otherwise T1 is a single cycle.
module alu_sequencer #(
  localparam int unsigned OP_W  = 5,
  localparam int unsigned SEL_W = 4,
  localparam int unsigned NREG  = 16,
  localparam int unsigned CNT_W = 16,
  localparam int unsigned IR_W  = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             mem_ready,
  input  logic [IR_W-1:0]  ir,
  output logic             PCout,
  output logic             MARin,
  output logic             incPC,
  output logic             PCin,
  output logic             read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             Zin,
  output logic             ZLowOut,
  output logic [NREG-1:0]  Rin,
  output logic [NREG-1:0]  Rout,
  output logic [OP_W-1:0]  opcode,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [OP_W-1:0] ALU_LO = OP_W'(3);
  localparam logic [OP_W-1:0] ALU_HI = OP_W'(12);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_T5   = 3'd6
  } state_t;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic pc_in;
    logic rd;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic y_in;
    logic z_in;
    logic zlow_out;
  } strobe_t;

  state_t            state, state_d;
  strobe_t           strb_q, strb_d;
  logic [NREG-1:0]   rin_d, rout_d;
  logic [OP_W-1:0]   opcode_d;
  logic [OP_W-1:0]   op_q;
  logic [SEL_W-1:0]  ra_q, rc_q;
  logic [OP_W-1:0]   ir_op;
  logic [SEL_W-1:0]  ir_ra, ir_rb, ir_rc;
  logic              legal;

  assign ir_op = ir[31:27];
  assign ir_ra = ir[26:23];
  assign ir_rb = ir[22:19];
  assign ir_rc = ir[18:15];
  assign legal = (ir_op >= ALU_LO) && (ir_op <= ALU_HI);

  // Low IR bits carry no information for this instruction class.
  logic unused_ir_low;
  assign unused_ir_low = ^ir[14:0];

`ifndef SEQ_MEM_WAIT_EN
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
`endif

  function automatic logic [NREG-1:0] onehot(input logic [SEL_W-1:0] sel);
    onehot = NREG'(1) << sel;
  endfunction

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (start) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1: begin
`ifdef SEQ_MEM_WAIT_EN
        if (mem_ready) state_d = S_T2;
`else
        state_d = S_T2;
`endif
      end
      S_T2:    state_d = legal ? S_T3 : S_IDLE;
      S_T3:    state_d = S_T4;
      S_T4:    state_d = S_T5;
      S_T5:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state so every output is a register aligned with state
  always_comb begin
    strb_d   = '0;
    rin_d    = '0;
    rout_d   = '0;
    opcode_d = '0;
    case (state_d)
      S_T0: begin
        strb_d.pc_out = 1'b1;
        strb_d.mar_in = 1'b1;
        strb_d.inc_pc = 1'b1;
      end
      S_T1: begin
        strb_d.pc_in  = 1'b1;
        strb_d.rd     = 1'b1;
        strb_d.mdr_in = 1'b1;
      end
      S_T2: begin
        strb_d.mdr_out = 1'b1;
        strb_d.ir_in   = 1'b1;
      end
      // T3 is only entered from T2, where ir is still the live source
      S_T3: begin
        strb_d.y_in = 1'b1;
        rout_d      = onehot(ir_rb);
      end
      S_T4: begin
        strb_d.z_in = 1'b1;
        rout_d      = onehot(rc_q);
        opcode_d    = op_q;
      end
      S_T5: begin
        strb_d.zlow_out = 1'b1;
        rin_d           = onehot(ra_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state       <= S_IDLE;
      strb_q      <= '0;
      Rin         <= '0;
      Rout        <= '0;
      opcode      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      instr_count <= '0;
      op_q        <= '0;
      ra_q        <= '0;
      rc_q        <= '0;
    end else begin
      state   <= state_d;
      strb_q  <= strb_d;
      Rin     <= rin_d;
      Rout    <= rout_d;
      opcode  <= opcode_d;
      busy    <= (state_d != S_IDLE);
      done    <= (state == S_T5);
      illegal <= (state == S_T2) && !legal;
      if (state == S_T5) instr_count <= instr_count + CNT_W'(1);
      // Capture the fields needed after T3, since ir may change afterwards
      if (state == S_T2) begin
        op_q <= ir_op;
        ra_q <= ir_ra;
        rc_q <= ir_rc;
      end
    end
  end

  assign PCout   = strb_q.pc_out;
  assign MARin   = strb_q.mar_in;
  assign incPC   = strb_q.inc_pc;
  assign PCin    = strb_q.pc_in;
  assign read    = strb_q.rd;
  assign MDRin   = strb_q.mdr_in;
  assign MDRout  = strb_q.mdr_out;
  assign IRin    = strb_q.ir_in;
  assign Yin     = strb_q.y_in;
  assign Zin     = strb_q.z_in;
  assign ZLowOut = strb_q.zlow_out;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer against a per-cycle expectation model.
module tb_alu_sequencer;

  logic        clock;
  logic        clear;
  logic        start;
  logic        mem_ready;
  logic [31:0] ir;
  logic        PCout, MARin, incPC, PCin, read, MDRin, MDRout, IRin, Yin, Zin, ZLowOut;
  logic [15:0] Rin, Rout;
  logic [4:0]  opcode;
  logic        busy, done, illegal;
  logic [15:0] instr_count;

  alu_sequencer dut (
    .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir),
    .PCout(PCout), .MARin(MARin), .incPC(incPC), .PCin(PCin), .read(read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .ZLowOut(ZLowOut), .Rin(Rin), .Rout(Rout), .opcode(opcode), .busy(busy),
    .done(done), .illegal(illegal), .instr_count(instr_count)
  );

`ifdef SEQ_MEM_WAIT_EN
  localparam bit MEM_WAIT = 1'b1;
`else
  localparam bit MEM_WAIT = 1'b0;
`endif

  // Strobe order: PCout MARin incPC PCin read MDRin MDRout IRin Yin Zin ZLowOut
  typedef struct packed {
    logic [10:0] strb;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  op;
    logic        busy;
    logic        done;
    logic        illegal;
  } obs_t;

  obs_t        expq[$];
  obs_t        zero_obs;
  int          vectors;
  int          errors;
  logic [15:0] model_count;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic obs_t snap();
    obs_t o;
    o.strb    = {PCout, MARin, incPC, PCin, read, MDRin, MDRout, IRin, Yin, Zin, ZLowOut};
    o.rin     = Rin;
    o.rout    = Rout;
    o.op      = opcode;
    o.busy    = busy;
    o.done    = done;
    o.illegal = illegal;
    return o;
  endfunction

  function automatic obs_t ob(input logic [10:0] s, input logic [15:0] ri, input logic [15:0] ro,
                              input logic [4:0] op, input logic b, input logic d, input logic il);
    obs_t o;
    o.strb = s; o.rin = ri; o.rout = ro; o.op = op; o.busy = b; o.done = d; o.illegal = il;
    return o;
  endfunction

  function automatic bit is_alu(input logic [4:0] op);
    return (op >= 5'd3) && (op <= 5'd12);
  endfunction

  // Expected observation for every cycle after start, straight from the state/strobe table
  task automatic plan(input logic [31:0] irv, input int waits);
    logic [4:0]  op;
    logic [15:0] one;
    op  = irv[31:27];
    one = 16'd1;
    expq.delete();
    expq.push_back(ob(11'h700, '0, '0, '0, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i <= waits; i++) expq.push_back(ob(11'h0E0, '0, '0, '0, 1'b1, 1'b0, 1'b0));
    expq.push_back(ob(11'h018, '0, '0, '0, 1'b1, 1'b0, 1'b0));
    if (is_alu(op)) begin
      expq.push_back(ob(11'h004, '0, one << irv[22:19], '0, 1'b1, 1'b0, 1'b0));
      expq.push_back(ob(11'h002, '0, one << irv[18:15], op, 1'b1, 1'b0, 1'b0));
      expq.push_back(ob(11'h001, one << irv[26:23], '0, '0, 1'b1, 1'b0, 1'b0));
      expq.push_back(ob(11'h000, '0, '0, '0, 1'b0, 1'b1, 1'b0));
    end else begin
      expq.push_back(ob(11'h000, '0, '0, '0, 1'b0, 1'b0, 1'b1));
    end
    expq.push_back(zero_obs);
    expq.push_back(zero_obs);
  endtask

  // Entered and left at a falling edge with the DUT idle
  task automatic run_instr(input logic [31:0] irv, input int waits, input bit restart, input string tag);
    obs_t got;
    int   n;
    plan(irv, waits);
    n         = expq.size();
    ir        = irv;
    start     = 1'b1;
    mem_ready = MEM_WAIT ? 1'b0 : 1'($urandom_range(0, 1));
    for (int k = 1; k <= n; k++) begin
      @(negedge clock);
      got = snap();
      vectors++;
      if (got !== expq[k-1]) begin
        errors++;
        $display("FAIL %s cycle %0d: observed %h required %h", tag, k, got, expq[k-1]);
      end
      if (restart && k < n - 2) start = (k == 3 + waits) ? 1'b1 : 1'($urandom_range(0, 1));
      else start = 1'b0;
      if (k >= 4 + waits) ir = $urandom();
      if (MEM_WAIT) mem_ready = (k == 2 + waits);
      else mem_ready = 1'($urandom_range(0, 1));
    end
    if (is_alu(irv[31:27])) model_count = model_count + 16'd1;
    vectors++;
    if (instr_count !== model_count) begin
      errors++;
      $display("FAIL %s instr_count: observed %h required %h", tag, instr_count, model_count);
    end
  endtask

  function automatic logic [31:0] rand_legal();
    logic [4:0] op;
    op = 5'($urandom_range(3, 12));
    return {op, 27'($urandom())};
  endfunction

  task automatic test_reset();
    clear = 1'b0; start = 1'b0; mem_ready = 1'b0; ir = '0;
    @(negedge clock);
    vectors++;
    if (snap() !== zero_obs) begin
      errors++; $display("FAIL reset_outputs: observed %h required %h", snap(), zero_obs);
    end
    vectors++;
    if (instr_count !== 16'h0000) begin
      errors++; $display("FAIL reset_count: observed %h required 0000", instr_count);
    end
    clear = 1'b1;
    repeat (2) @(negedge clock);
    vectors++;
    if (snap() !== zero_obs) begin
      errors++; $display("FAIL reset_idle: observed %h required %h", snap(), zero_obs);
    end
    model_count = 16'h0000;
  endtask

  task automatic test_example();
    run_instr({5'b01000, 4'd4, 4'd3, 4'd7, 15'h0}, 0, 1'b0, "example");
  endtask

  task automatic test_random_legal();
    for (int i = 0; i < 12; i++) run_instr(rand_legal(), 0, 1'b0, "legal");
  endtask

  task automatic test_illegal();
    logic [4:0] op;
    int r;
    run_instr({5'b11111, 27'($urandom())}, 0, 1'b0, "illegal_1f");
    for (int i = 0; i < 6; i++) begin
      r  = int'($urandom_range(0, 21));
      op = (r < 3) ? 5'(r) : 5'(r + 10);
      run_instr({op, 27'($urandom())}, 0, 1'b0, "illegal");
    end
  endtask

  task automatic test_mem_wait();
    if (MEM_WAIT) begin
      run_instr(rand_legal(), 3, 1'b0, "wait3");
      for (int i = 0; i < 4; i++) run_instr(rand_legal(), int'($urandom_range(0, 4)), 1'b0, "wait_rand");
    end else begin
      for (int i = 0; i < 4; i++) run_instr(rand_legal(), 0, 1'b0, "ready_ignored");
    end
  endtask

  task automatic test_start_while_busy();
    for (int i = 0; i < 4; i++) run_instr(rand_legal(), 0, 1'b1, "start_busy");
  endtask

  task automatic test_clear_mid();
    obs_t t4;
    logic [31:0] irv;
    logic [15:0] one;
    one       = 16'd1;
    irv       = rand_legal();
    ir        = irv;
    start     = 1'b1;
    mem_ready = 1'b1;
    repeat (5) begin
      @(negedge clock);
      start = 1'b0;
    end
    t4 = ob(11'h002, '0, one << irv[18:15], irv[31:27], 1'b1, 1'b0, 1'b0);
    vectors++;
    if (snap() !== t4) begin
      errors++; $display("FAIL clear_mid_t4: observed %h required %h", snap(), t4);
    end
    #2 clear = 1'b0;
    #1;
    vectors++;
    if (snap() !== zero_obs || instr_count !== 16'h0000) begin
      errors++;
      $display("FAIL clear_async: observed %h/%h required %h/0000", snap(), instr_count, zero_obs);
    end
    model_count = 16'h0000;
    @(negedge clock);
    clear = 1'b1;
    repeat (3) begin
      @(negedge clock);
      vectors++;
      if (snap() !== zero_obs) begin
        errors++; $display("FAIL clear_no_done: observed %h required %h", snap(), zero_obs);
      end
    end
    run_instr(rand_legal(), 0, 1'b0, "after_clear");
  endtask

  task automatic test_count_wrap();
    force dut.instr_count = 16'hFFFF;
    @(negedge clock);
    release dut.instr_count;
    model_count = 16'hFFFF;
    @(negedge clock);
    run_instr(rand_legal(), 0, 1'b0, "wrap");
    run_instr(rand_legal(), 0, 1'b0, "post_wrap");
  endtask

  initial begin
    vectors  = 0;
    errors   = 0;
    zero_obs = '0;
    test_reset();
    test_example();
    test_random_legal();
    test_illegal();
    test_mem_wait();
    test_start_while_busy();
    test_clear_mid();
    test_count_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 clock  input  1  single system clock; all state changes on rising edge.
REQ-002 clear  input  1  asynchronous, active-low reset; low forces reset state immediately.
REQ-003 start  input  1  request to execute one register-register ALU instruction; sampled in IDLE only.
REQ-004 mem_ready  input  1  memory read complete; qualifies the instruction read in T1.
REQ-005 ir  input  32  IR contents: opcode ir[31:27], Ra ir[26:23], Rb ir[22:19], Rc ir[18:15].
REQ-006 PCout, MARin, incPC, PCin, read, MDRin, MDRout, IRin, Yin, Zin, ZLowOut  output  1 each  datapath control strobes.
REQ-007 Rin  output  16  one-hot register write enables, bit n drives RnIn.
REQ-008 Rout  output  16  one-hot register bus drivers, bit n drives RnOut.
REQ-009 opcode  output  5  ALU operation select.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse on successful completion.
REQ-012 illegal  output  1  one-cycle pulse on an opcode outside the ALU class.
REQ-013 instr_count  output  16  count of completed instructions.

Function
REQ-014 States: IDLE, T0, T1, T2, T3, T4, T5; all outputs registered and decoded from the present state (Moore).
REQ-015 IDLE -> T0 when start=1; otherwise stay in IDLE.
REQ-016 Asserted strobes by state:
  - T0: PCout, MARin, incPC.
  - T1: PCin, read, MDRin.
  - T2: MDRout, IRin.
  - T3: Rout[Rb], Yin.
  - T4: Rout[Rc], Zin, opcode=ir[31:27].
  - T5: ZLowOut, Rin[Ra].
  All other outputs are 0; opcode is 5'b00000 outside T4.
REQ-017 T0->T1, T2->T3, T3->T4 and T4->T5 are unconditional.
REQ-018 T1->T2 behaviour depends on SEQ_MEM_WAIT_EN (REQ-027).
REQ-019 ALU class is opcode 5'b00011 through 5'b01100 inclusive; ir is sampled on the T2->T3 edge.
REQ-020 Illegal opcode: pulse illegal in the state following T2, go to IDLE instead of T3, and assert no Rout, Yin, Zin or Rin.
REQ-021 T5 -> IDLE; done pulses for the cycle in which the state is IDLE after T5.
REQ-022 instr_count increments by 1 on the T5->IDLE edge, wraps 16'hFFFF -> 16'h0000, and does not count illegal instructions.
REQ-023 start while busy is ignored and not queued.
REQ-024 Rin and Rout are never both nonzero in the same cycle; at most one bit of each is set.

Reset
REQ-025 clear=0 asynchronously forces:
  - state to IDLE;
  - all strobes, Rin, Rout, opcode, done, illegal and instr_count to 0.
REQ-026 Reset mid-instruction abandons it: no done pulse and no count increment; after clear returns high, the block is in IDLE and waits for start.

Configuration
REQ-027 Macro SEQ_MEM_WAIT_EN:
  - Defined: T1 holds, with its strobes held asserted, until mem_ready=1, then goes to T2.
  - Undefined: T1 lasts exactly one cycle, mem_ready is ignored, and the fixed latency from start to done is 7 cycles.

Verification
REQ-028 Reset, then start=1 for 1 cycle with ir opcode 5'b01000, Ra=4, Rb=3, Rc=7 -> T3 Rout=16'h0008 with Yin; T4 Rout=16'h0080, Zin, opcode=01000; T5 Rin=16'h0010 with ZLowOut; done pulses once; instr_count=1.
REQ-029 With SEQ_MEM_WAIT_EN defined, mem_ready held low 3 cycles in T1 -> PCin, read, MDRin stay high 4 cycles, then T2; done 3 cycles later than the no-wait case.
REQ-030 ir opcode 5'b11111 -> illegal pulses once; Rin=0, Rout=0, Zin=0 throughout; instr_count unchanged; state returns to IDLE.
REQ-031 clear driven low during T4 -> all outputs 0 immediately with no clock edge; no done pulse; next start runs a full instruction normally.
REQ-032 start pulsed again during T2 -> ignored; exactly one done pulse.
REQ-033 Preload instr_count to 16'hFFFF via 65535 instructions, then run one more -> instr_count=16'h0000.
